// File: rtl/dds_wavegen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dds_wavegen_if                                            |
// | Purpose  : Control and sample bundle between a DDS source consumer   |
// |            (master) and the dds_wavegen generator (slave).           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface dds_wavegen_if #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 8
);
  logic               CE;
  logic               PHASE_RST;
  logic [PHASE_W-1:0] FREQ;
  logic [PHASE_W-1:0] PHASE_OFS;
  logic [1:0]         MODE;
  logic [OUT_W-1:0]   DOUT;
  logic               OUT_VALID;
  logic               WRAP;

  modport master (
    output CE, PHASE_RST, FREQ, PHASE_OFS, MODE,
    input  DOUT, OUT_VALID, WRAP
  );

  modport slave (
    input  CE, PHASE_RST, FREQ, PHASE_OFS, MODE,
    output DOUT, OUT_VALID, WRAP
  );
endinterface
`default_nettype wire

// File: rtl/dds_wavegen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dds_wavegen                                               |
// | Purpose  : Phase-accumulator DDS with phase offset, quarter-wave sine |
// |            table and sine/triangle/saw/square select. Three-stage    |
// |            pipeline paced by CE; offset-binary output.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dds_wavegen #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 7,
  parameter int OUT_W   = 8
) (
  input  wire logic    CLK,
  input  wire logic    RESET_N,
  dds_wavegen_if.slave bus
);

  localparam int  c_LUT_N = 2 ** LUT_AW;
  // Only the top phase bits feed the table index or the shaped waveforms.
  localparam int  c_KEEP  = (LUT_AW + 2 > OUT_W + 1) ? (LUT_AW + 2) : (OUT_W + 1);
  localparam real c_PI    = 3.14159265358979323846;
  localparam real c_AMP   = real'(2 ** (OUT_W - 1) - 1);

  localparam logic [OUT_W-1:0] c_MID    = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] c_MID_LO = {1'b0, {(OUT_W-1){1'b1}}};

  localparam logic [1:0] c_MODE_SINE = 2'd0;
  localparam logic [1:0] c_MODE_TRI  = 2'd1;
  localparam logic [1:0] c_MODE_SAW  = 2'd2;
  localparam logic [1:0] c_MODE_SQR  = 2'd3;

  // Quarter-wave table sampled at half-step points so mirrored quadrants
  // reuse every entry without duplicating the 0 and peak endpoints.
  logic [OUT_W-2:0] w_lut [c_LUT_N];

  for (genvar gi = 0; gi < c_LUT_N; gi++) begin : g_lut
    localparam real c_ANG = 2.0 * c_PI * (real'(gi) + 0.5) / real'(4 * c_LUT_N);
    localparam int  c_VAL = $rtoi(c_AMP * $sin(c_ANG) + 0.5);
    assign w_lut[gi] = c_VAL[OUT_W-2:0];
  end

  logic [PHASE_W-1:0] r_acc;
  logic               r_wrap_flag;
  logic [PHASE_W:0]   w_sum;
  logic [PHASE_W-1:0] w_ph;
  logic               w_unused_ph;

  logic [c_KEEP-1:0]  r_ph1;
  logic [1:0]         r_mode1;
  logic               r_wrap1;
  logic               r_v1;

  logic [LUT_AW-1:0]  w_idx;
  logic [LUT_AW-1:0]  w_addr;

  logic [OUT_W-2:0]   r_s2;
  logic [OUT_W:0]     r_ph2;
  logic [1:0]         r_mode2;
  logic               r_wrap2;
  logic               r_v2;

  logic [OUT_W-1:0]   w_sample;
  logic [OUT_W-1:0]   r_dout;
  logic               r_out_valid;
  logic               r_wrap_out;

  assign w_sum       = {1'b0, r_acc} + {1'b0, bus.FREQ};
  assign w_ph        = r_acc + bus.PHASE_OFS;
  assign w_unused_ph = ^w_ph[PHASE_W-c_KEEP-1:0];

  // Phase accumulator: clear has priority over the increment; carry marks a new period.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_acc       <= '0;
      r_wrap_flag <= 1'b0;
    end else if (bus.CE) begin
      if (bus.PHASE_RST) begin
        r_acc       <= '0;
        r_wrap_flag <= 1'b1;
      end else begin
        {r_wrap_flag, r_acc} <= w_sum;
      end
    end
  end

  // Stage 1: capture offset phase from the pre-update accumulator, plus mode and wrap.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ph1   <= '0;
      r_mode1 <= c_MODE_SINE;
      r_wrap1 <= 1'b0;
      r_v1    <= 1'b0;
    end else begin
      r_v1 <= bus.CE;
      if (bus.CE) begin
        r_ph1   <= w_ph[PHASE_W-1 -: c_KEEP];
        r_mode1 <= bus.MODE;
        r_wrap1 <= r_wrap_flag;
      end
    end
  end

  // Odd quadrants walk the table backwards.
  assign w_idx  = r_ph1[c_KEEP-3 -: LUT_AW];
  assign w_addr = r_ph1[c_KEEP-2] ? ~w_idx : w_idx;

  // Stage 2: table read and forwarding of the phase bits the shapers need.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s2    <= '0;
      r_ph2   <= '0;
      r_mode2 <= c_MODE_SINE;
      r_wrap2 <= 1'b0;
      r_v2    <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2    <= w_lut[w_addr];
        r_ph2   <= r_ph1[c_KEEP-1 -: OUT_W+1];
        r_mode2 <= r_mode1;
        r_wrap2 <= r_wrap1;
      end
    end
  end

  // Waveform shaping; r_ph2[OUT_W] is the phase MSB (upper half-period).
  always_comb begin
    w_sample = c_MID;
    case (r_mode2)
      c_MODE_SINE: w_sample = r_ph2[OUT_W] ? (c_MID_LO - {1'b0, r_s2})
                                           : (c_MID + {1'b0, r_s2});
      c_MODE_TRI:  w_sample = r_ph2[OUT_W] ? ~r_ph2[OUT_W-1:0] : r_ph2[OUT_W-1:0];
      c_MODE_SAW:  w_sample = r_ph2[OUT_W -: OUT_W];
      c_MODE_SQR:  w_sample = {OUT_W{~r_ph2[OUT_W]}};
      default:     w_sample = c_MID;
    endcase
  end

  // Stage 3: output register; sample holds between valid strobes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dout      <= c_MID;
      r_out_valid <= 1'b0;
      r_wrap_out  <= 1'b0;
    end else begin
      r_out_valid <= r_v2;
      r_wrap_out  <= r_wrap2 & r_v2;
      if (r_v2) begin
        r_dout <= w_sample;
      end
    end
  end

  assign bus.DOUT      = r_dout;
  assign bus.OUT_VALID = r_out_valid;
  assign bus.WRAP      = r_wrap_out;

endmodule
`default_nettype wire

// File: tb/tb_dds_wavegen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dds_wavegen                                            |
// | Purpose  : Directed self-checking bench for dds_wavegen.             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_dds_wavegen;

  logic CLK;
  logic RESET_N;
  int   total;
  int   bad;

  dds_wavegen_if #(.PHASE_W(32), .OUT_W(8)) bus ();

  dds_wavegen #(.PHASE_W(32), .LUT_AW(7), .OUT_W(8)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.CE        = 1'b0;
    bus.PHASE_RST = 1'b0;
    RESET_N       = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  // Golden sine: quarter table from the closed-form definition, full-wave by symmetry.
  function automatic logic [7:0] sine_ref(input logic [31:0] ph);
    int  a;
    int  s;
    real ang;
    a   = ph[30] ? (127 - int'(ph[29:23])) : int'(ph[29:23]);
    ang = 2.0 * 3.14159265358979323846 * (real'(a) + 0.5) / 512.0;
    s   = $rtoi(127.0 * $sin(ang) + 0.5);
    return ph[31] ? 8'(127 - s) : 8'(128 + s);
  endfunction

  logic [31:0] ofs_tab [4];
  logic [7:0]  ofs_exp [4];
  logic [7:0]  sine_obs [512];
  logic [7:0]  exp_dout;
  logic [31:0] ph_exp;
  int          mn;
  int          mx;
  int          n;
  int          m;
  int          ce_pat [5];

  initial begin
    total = 0;
    bad   = 0;
    bus.CE        = 1'b0;
    bus.PHASE_RST = 1'b0;
    bus.FREQ      = '0;
    bus.PHASE_OFS = '0;
    bus.MODE      = 2'd0;
    RESET_N       = 1'b0;

    // Reset state
    tick();
    chk("rst_dout",  32'(bus.DOUT), 32'h80);
    chk("rst_valid", 32'(bus.OUT_VALID), 32'h0);
    chk("rst_wrap",  32'(bus.WRAP), 32'h0);

    // Static phase offsets, FREQ=0, sine
    do_reset();
    bus.CE = 1'b1;
    tick(); chk("lat_v0", 32'(bus.OUT_VALID), 32'h0);
    tick(); chk("lat_v1", 32'(bus.OUT_VALID), 32'h0);
    tick(); chk("lat_v2", 32'(bus.OUT_VALID), 32'h1);
    chk("ofs0_first", 32'(bus.DOUT), 32'h81);
    ofs_tab = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
    ofs_exp = '{8'h81, 8'hFF, 8'h7E, 8'h00};
    for (int i = 0; i < 4; i++) begin
      bus.PHASE_OFS = ofs_tab[i];
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("ofs_valid", 32'(bus.OUT_VALID), 32'h1);
      end
      chk("ofs_dout", 32'(bus.DOUT), 32'(ofs_exp[i]));
    end
    bus.PHASE_OFS = '0;

    // Saw, two periods
    do_reset();
    bus.FREQ = 32'h0200_0000;
    bus.MODE = 2'd2;
    bus.CE   = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 256; k++) begin
      chk("saw_dout",  32'(bus.DOUT), 32'((k * 2) & 255));
      chk("saw_wrap",  32'(bus.WRAP), ((k % 128) == 0 && k != 0) ? 32'h1 : 32'h0);
      chk("saw_valid", 32'(bus.OUT_VALID), 32'h1);
      tick();
    end

    // Triangle, one period
    do_reset();
    bus.MODE = 2'd1;
    bus.CE   = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 128; k++) begin
      chk("tri_dout", 32'(bus.DOUT), (k < 64) ? 32'(k * 4) : 32'(255 - (k - 64) * 4));
      tick();
    end

    // Square, one period
    do_reset();
    bus.MODE = 2'd3;
    bus.CE   = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 128; k++) begin
      chk("sqr_dout", 32'(bus.DOUT), (k < 64) ? 32'hFF : 32'h00);
      tick();
    end

    // Sine, full 512-sample period
    do_reset();
    bus.FREQ = 32'h0080_0000;
    bus.MODE = 2'd0;
    bus.CE   = 1'b1;
    tick(); tick(); tick();
    mn = 255;
    mx = 0;
    for (int k = 0; k < 512; k++) begin
      sine_obs[k] = bus.DOUT;
      chk("sine_gold", 32'(bus.DOUT), 32'(sine_ref(32'(k) * 32'h0080_0000)));
      if (int'(bus.DOUT) < mn) mn = int'(bus.DOUT);
      if (int'(bus.DOUT) > mx) mx = int'(bus.DOUT);
      tick();
    end
    for (int k = 0; k < 256; k++) begin
      chk("sine_sym", 32'(sine_obs[k]) + 32'(sine_obs[k + 256]), 32'hFF);
    end
    chk("sine_min", 32'(mn), 32'h00);
    chk("sine_max", 32'(mx), 32'hFF);

    // CE pattern 1-0-1-1-0: valid follows 3 edges later, acc and DOUT hold otherwise
    do_reset();
    bus.FREQ = 32'h0200_0000;
    bus.MODE = 2'd2;
    ce_pat   = '{1, 0, 1, 1, 0};
    exp_dout = 8'h80;
    n        = 0;
    for (int j = 0; j < 8; j++) begin
      bus.CE = (j < 5) ? ce_pat[j][0] : 1'b0;
      tick();
      m = (j >= 2) ? ((j - 2 < 5) ? ce_pat[j - 2] : 0) : 0;
      if (m != 0) begin
        exp_dout = 8'(n * 2);
        n++;
      end
      chk("ce_valid", 32'(bus.OUT_VALID), 32'(m));
      chk("ce_dout",  32'(bus.DOUT), 32'(exp_dout));
    end

    // PHASE_RST mid-run with a large tuning word
    do_reset();
    bus.FREQ = 32'h3000_0000;
    bus.MODE = 2'd0;
    bus.CE   = 1'b1;
    for (int j = 0; j < 11; j++) begin
      bus.PHASE_RST = (j == 5);
      tick();
      if (j >= 2) begin
        n      = j - 2;
        ph_exp = (n <= 5) ? 32'(n) * 32'h3000_0000 : 32'(n - 6) * 32'h3000_0000;
        chk("prst_dout", 32'(bus.DOUT), 32'(sine_ref(ph_exp)));
        chk("prst_wrap", 32'(bus.WRAP), (n == 6) ? 32'h1 : 32'h0);
      end
    end
    bus.PHASE_RST = 1'b0;

    // Asynchronous reset between clock edges
    bus.FREQ = 32'h0200_0000;
    for (int j = 0; j < 6; j++) tick();
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_dout",  32'(bus.DOUT), 32'h80);
    chk("arst_valid", 32'(bus.OUT_VALID), 32'h0);
    chk("arst_wrap",  32'(bus.WRAP), 32'h0);
    tick();
    RESET_N = 1'b1;
    tick(); chk("arst_v0", 32'(bus.OUT_VALID), 32'h0);
    tick(); chk("arst_v1", 32'(bus.OUT_VALID), 32'h0);
    tick();
    chk("arst_v2",    32'(bus.OUT_VALID), 32'h1);
    chk("arst_first", 32'(bus.DOUT), 32'h81);
    chk("arst_fwrap", 32'(bus.WRAP), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
